dmem_port_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: the pipeline MEM stage (req 0) and the

---
 rtl/dmem_port_arbiter_if.sv | 28 ++
 rtl/dmem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bundle for the data-memory port arbiter: request
// handshake plus the one-cycle response.
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic          we;
    logic [2:0]    func3;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    // Requester drives the request and observes the response.
    modport master (
        output valid, we, func3, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    // Arbiter consumes the request and produces the response.
    modport slave (
        input  valid, we, func3, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter for the single data-memory port.
// One transaction in flight: accept in IDLE, drive memory for one ACCESS
// cycle, respond on the following cycle. Memory controls are registered
// so the combinationally-written array never sees glitches.

// Per-requester response register: pulse rvalid, hold rdata/err.
module dmem_port_arbiter_rsp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fire,
    input  logic          err_in,
    input  logic [DW-1:0] rdata_in,
    output logic          rvalid,
    output logic          err,
    output logic [DW-1:0] rdata
);
    // Response pulse; data/err only change when this requester owns the reply.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= fire;
            if (fire) begin
                err   <= err_in;
                rdata <= rdata_in;
            end
        end
    end
endmodule

module dmem_port_arbiter #(
    parameter int   AW       = 32,
    parameter int   DW       = 32,
    parameter logic RESET_LP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   r0,
    dmem_port_arbiter_if.slave   r1,
    output logic                 mem_we,
    output logic [2:0]           mem_func3,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);
    localparam int NREQ = 2;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state_q, state_d;

    // Requester views flattened so the datapath can index by grant id.
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_we;
    logic [NREQ-1:0][2:0]    req_func3;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_wdata;

    logic [NREQ-1:0]         ready;
    logic [NREQ-1:0]         rsp_fire;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_err;
    logic [NREQ-1:0][DW-1:0] rsp_rdata;

    logic          grant;
    logic          accept;
    logic          acc_err;
    logic          last_q;
    logic          own_q;
    logic          we_q;
    logic          err_q;
    logic [DW-1:0] load_data;

    assign req_valid = {r1.valid, r0.valid};
    assign req_we    = {r1.we,    r0.we};
    assign req_func3 = {r1.func3, r0.func3};
    assign req_addr  = {r1.addr,  r0.addr};
    assign req_wdata = {r1.wdata, r0.wdata};

    assign r0.ready  = ready[0];
    assign r1.ready  = ready[1];
    assign r0.rvalid = rsp_valid[0];
    assign r1.rvalid = rsp_valid[1];
    assign r0.err    = rsp_err[0];
    assign r1.err    = rsp_err[1];
    assign r0.rdata  = rsp_rdata[0];
    assign r1.rdata  = rsp_rdata[1];

    // Screen a request: illegal width code, store with a load-only width,
    // or an access not aligned to its size.
    function automatic logic req_err(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
        logic e;
        case (f3)
            3'd0:    e = 1'b0;
            3'd4:    e = we;
            3'd1:    e = a[0];
            3'd5:    e = we | a[0];
            3'd2:    e = (a != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Arbitration and next state: on a tie the requester not granted last wins.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid == 2'b11) grant = ~last_q;
                else                    grant = req_valid[1];
                accept = (|req_valid) & ~reset;
                if (accept) state_d = ACCESS;
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc_err = req_err(req_we[grant], req_func3[grant], req_addr[grant][1:0]);

    // Latch the granted request into the memory-facing registers; mem_we
    // is only ever high for the single ACCESS cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= RESET_LP;
            own_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_func3 <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            last_q    <= grant;
            own_q     <= grant;
            we_q      <= req_we[grant];
            err_q     <= acc_err;
            mem_we    <= req_we[grant] & ~acc_err;
            mem_func3 <= req_func3[grant];
            mem_addr  <= req_addr[grant];
            mem_wdata <= req_wdata[grant];
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // Stores and screened-out requests return zero data.
    assign load_data = (we_q | err_q) ? '0 : mem_rdata;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign ready[i]    = accept & (grant == i[0]);
        assign rsp_fire[i] = (state_q == ACCESS) & (own_q == i[0]);

        dmem_port_arbiter_rsp #(.DW(DW)) u_rsp (
            .clk      (clk),
            .reset    (reset),
            .fire     (rsp_fire[i]),
            .err_in   (err_q),
            .rdata_in (load_data),
            .rvalid   (rsp_valid[i]),
            .err      (rsp_err[i]),
            .rdata    (rsp_rdata[i])
        );
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed cases plus randomized traffic
// checked against a transaction-level model of arbitration and memory.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_port_arbiter_if #(.AW(32), .DW(32)) r0_if ();
    dmem_port_arbiter_if #(.AW(32), .DW(32)) r1_if ();

    dmem_port_arbiter #(.AW(32), .DW(32), .RESET_LP(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .r0        (r0_if),
        .r1        (r1_if),
        .mem_we    (mem_we),
        .mem_func3 (mem_func3),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Load result for a width code from the little-endian word at the address.
    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd5:    return {16'd0, w[15:0]};
            3'd2:    return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    endfunction

    // Memory array seen by the DUT.
    logic [7:0] tbmem [0:255];
    logic       poke_en = 1'b0;
    logic [7:0] poke_a  = 8'd0;
    logic [7:0] poke_d  = 8'd0;
    logic [7:0] ma;
    assign ma = mem_addr[7:0];
    assign mem_rdata = ld(mem_func3, {tbmem[ma+8'd3], tbmem[ma+8'd2], tbmem[ma+8'd1], tbmem[ma]});

    // Memory writes land while mem_we is high; pokes preload content.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++)
                if (k < nbytes(mem_func3)) tbmem[ma + k[7:0]] <= mem_wdata[8*k +: 8];
        end else if (poke_en) begin
            tbmem[poke_a] <= poke_d;
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [0:255];
    logic        last;
    logic [31:0] last_rd [2];
    logic [1:0]  pend;
    logic        opwe [2];
    logic [2:0]  opf3 [2];
    logic [31:0] opad [2];
    logic [31:0] opwd [2];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {ref_mem[b+8'd3], ref_mem[b+8'd2], ref_mem[b+8'd1], ref_mem[b]};
    endfunction

    function automatic logic exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic illegal, store_bad, half_bad, word_bad;
        illegal   = (f3 == 3'd3) || (f3 >= 3'd6);
        store_bad = we && (f3 > 3'd2);
        half_bad  = ((f3 == 3'd1) || (f3 == 3'd5)) && a[0];
        word_bad  = (f3 == 3'd2) && (a[1:0] != 2'b00);
        return illegal || store_bad || half_bad || word_bad;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        r0_if.valid = pend[0]; r0_if.we = opwe[0]; r0_if.func3 = opf3[0];
        r0_if.addr  = opad[0]; r0_if.wdata = opwd[0];
        r1_if.valid = pend[1]; r1_if.we = opwe[1]; r1_if.func3 = opf3[1];
        r1_if.addr  = opad[1]; r1_if.wdata = opwd[1];
    endtask

    task automatic set_op(input int r, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        opwe[r] = we; opf3[r] = f3; opad[r] = a; opwd[r] = wd; pend[r] = 1'b1;
    endtask

    task automatic rand_op(input int r);
        logic [2:0] legal [5];
        logic [2:0] f3;
        logic [31:0] a;
        legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        f3 = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
        a  = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
        set_op(r, 1'($urandom_range(0, 1)), f3, a, $urandom);
    endtask

    // Serve everything pending; called at a negedge in IDLE, returns at the
    // negedge of the last response cycle. refill re-arms the winner so it
    // stays continuously valid.
    task automatic serve(input int refill);
        int          left;
        logic        g, e, mwe;
        logic [31:0] erd, ea, ewd;
        logic [2:0]  ef3;
        left = refill;
        while (pend != 2'b00) begin
            g   = (pend == 2'b11) ? ~last : pend[1];
            chk("ready0_at_accept", 32'(r0_if.ready), 32'(g == 1'b0));
            chk("ready1_at_accept", 32'(r1_if.ready), 32'(g == 1'b1));
            e   = exp_err(opwe[g], opf3[g], opad[g]);
            mwe = opwe[g] & ~e;
            ea  = opad[g]; ef3 = opf3[g]; ewd = opwd[g];
            erd = (opwe[g] || e) ? 32'd0 : ld(opf3[g], ref_word(opad[g]));
            if (mwe)
                for (int k = 0; k < nbytes(ef3); k++) ref_mem[ea[7:0] + k[7:0]] = ewd[8*k +: 8];
            last = g;
            @(posedge clk); #1;
            if (left > 0) begin rand_op(int'(g)); left--; end
            else pend[g] = 1'b0;
            drive_ports();
            @(negedge clk);
            chk("mem_we_access", 32'(mem_we), 32'(mwe));
            chk("mem_addr_access", mem_addr, ea);
            chk("mem_func3_access", 32'(mem_func3), 32'(ef3));
            chk("mem_wdata_access", mem_wdata, ewd);
            chk("ready_in_access", {30'd0, r1_if.ready, r0_if.ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("mem_we_after", 32'(mem_we), 32'd0);
            if (g) begin
                chk("r1_rvalid", 32'(r1_if.rvalid), 32'd1);
                chk("r1_rdata", r1_if.rdata, erd);
                chk("r1_err", 32'(r1_if.err), 32'(e));
                chk("r0_rvalid_idle", 32'(r0_if.rvalid), 32'd0);
                chk("r0_rdata_held", r0_if.rdata, last_rd[0]);
            end else begin
                chk("r0_rvalid", 32'(r0_if.rvalid), 32'd1);
                chk("r0_rdata", r0_if.rdata, erd);
                chk("r0_err", 32'(r0_if.err), 32'(e));
                chk("r1_rvalid_idle", 32'(r1_if.rvalid), 32'd0);
                chk("r1_rdata_held", r1_if.rdata, last_rd[1]);
            end
            last_rd[g] = erd;
        end
    endtask

    // Present new requests after a posedge, then serve them.
    task automatic launch(input int refill);
        @(posedge clk); #1;
        drive_ports();
        @(negedge clk);
        serve(refill);
    endtask

    initial begin
        logic [31:0] bw;
        pend = 2'b00; last = 1'b1; last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        for (int r = 0; r < 2; r++) begin
            opwe[r] = 1'b0; opf3[r] = 3'd0; opad[r] = 32'd0; opwd[r] = 32'd0;
        end
        drive_ports();
        reset = 1'b1;

        // Preload memory and model under reset; 0x10 holds 0xDEADBEEF.
        bw = 32'hDEADBEEF;
        poke_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            poke_a = 8'(i);
            poke_d = (i >= 16 && i < 20) ? bw[8*(i-16) +: 8] : 8'($urandom);
            ref_mem[i] = poke_d;
        end
        @(posedge clk); #1;
        poke_en = 1'b0;
        r0_if.valid = 1'b1;
        @(negedge clk);
        chk("reset_ready0", 32'(r0_if.ready), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_func3", 32'(mem_func3), 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_rsp", {r1_if.err, r0_if.err, r1_if.rvalid, r0_if.rvalid}, 32'd0);
        chk("reset_rdata0", r0_if.rdata, 32'd0);
        chk("reset_rdata1", r1_if.rdata, 32'd0);
        @(posedge clk); #1;
        r0_if.valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // r0 lw 0x10.
        set_op(0, 1'b0, 3'd2, 32'h10, 32'd0);
        launch(0);
        chk("lw_deadbeef", r0_if.rdata, 32'hDEADBEEF);

        // r1 sb 0x13 <- 0xAB, then read the word back.
        set_op(1, 1'b1, 3'd0, 32'h13, 32'hAB);
        launch(0);
        set_op(0, 1'b0, 3'd2, 32'h10, 32'd0);
        launch(0);
        chk("sb_readback", r0_if.rdata, 32'hABADBEEF);

        // Misaligned sw and an illegal-width load.
        set_op(0, 1'b1, 3'd2, 32'h102, 32'h12345678);
        launch(0);
        chk("sw_misaligned_err", 32'(r0_if.err), 32'd1);
        set_op(1, 1'b0, 3'd3, 32'h20, 32'd0);
        launch(0);
        chk("func3_3_err", 32'(r1_if.err), 32'd1);

        // Both continuously valid for 8 transactions: strict alternation.
        rand_op(0); rand_op(1);
        launch(6);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0:       rand_op(0);
                1:       rand_op(1);
                default: begin rand_op(0); rand_op(1); end
            endcase
            launch($urandom_range(0, 3));
        end

        // Reset during ACCESS of an r1 store aborts the response.
        set_op(1, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive_ports();
        @(negedge clk);
        chk("rst_abort_ready1", 32'(r1_if.ready), 32'd1);
        for (int k = 0; k < 4; k++) ref_mem[8'h40 + k[7:0]] = opwd[1][8*k +: 8];
        @(posedge clk); #1;
        pend = 2'b00; drive_ports();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_abort_mem_we_access", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_abort_mem_we", 32'(mem_we), 32'd0);
        chk("rst_abort_r1_rvalid", 32'(r1_if.rvalid), 32'd0);
        chk("rst_abort_r1_rdata", r1_if.rdata, 32'd0);
        last = 1'b1; last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_abort_r1_rvalid_late", 32'(r1_if.rvalid), 32'd0);

        // Tie right after reset goes to r0; then read back the aborted store.
        set_op(0, 1'b0, 3'd2, 32'h40, 32'd0);
        rand_op(1);
        launch(0);
        set_op(0, 1'b0, 3'd2, 32'h40, 32'd0);
        launch(0);
        chk("rst_store_landed", r0_if.rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
